mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multiply/divide sequencer for the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo issued from the E stage and owns the HI/LO registers.
- Models fixed multi-cycle latency with a busy counter.
- Generates the stall request the hazard unit uses to freeze F/D while an MDU-dependent instruction waits in D.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (min 1)
DIV_CYCLES, 10, busy cycles for div/divu (min 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
start  input  1  E-stage instruction is an MDU op this cycle
op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved (no-op)
a  input  32  rs operand (forwarded)
b  input  32  rt operand (forwarded)
d_md_use  input  1  D-stage instruction is mult/div/mf*/mt*
busy  output  1  operation in progress
stall_req  output  1  stall F/D this cycle
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset==0 at clk edge): state IDLE, count=0, busy=0, hi=0, lo=0, pending result regs=0. Takes priority over all other inputs; mid-operation reset aborts the op with no HI/LO write.
- States: IDLE, RUN.
- IDLE, start=1, op in {0..3}:
  - Latch result into pending regs.
  - Load count = MULT_CYCLES (op 0,1) or DIV_CYCLES (op 2,3).
  - Go to RUN; busy=1 from the next cycle.
- IDLE, start=1, op=4: hi<=a next edge. op=5: lo<=a next edge. No busy in either case. op 6/7: ignored.
- RUN: count decrements each edge. When count==1 at an edge: hi/lo <= pending, count<=0, state<=IDLE, busy=0 the following cycle.
- Latency: an op started at edge N sets busy high for exactly MULT_CYCLES/DIV_CYCLES cycles. HI/LO become visible the cycle busy falls.
- start during RUN (any op, including mthi/mtlo): ignored. Pipeline guarantees this cannot happen via stall_req; the block must still not corrupt state.
- stall_req = d_md_use & (busy | (start & op<=3)). Combinational.
- Arithmetic:
  - mult: signed 64-bit product, {hi,lo}. multu: unsigned.
  - div: lo = quotient truncated toward zero, hi = remainder with sign of dividend. divu: unsigned.
  - Overflow case a=0x80000000, b=0xFFFFFFFF (div): lo=0x80000000, hi=0.
  - b==0 (div/divu): op still takes DIV_CYCLES busy cycles; hi/lo retain prior values.
- hi/lo are registered outputs; mfhi/mflo read them directly and are stalled while busy.

Test Plan:
- Reset: drive reset=0 two cycles with start=1, op=0 -> hi=lo=0, busy=0, stall_req follows d_md_use&start only; release -> idle.
- mult a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=0 -> busy 10 cycles, hi/lo unchanged.
- mthi a=0x12345678, then mtlo a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated one edge each, busy never asserts.
- Hazard: start mult, hold d_md_use=1 -> stall_req=1 from the start cycle through the last busy cycle, 0 the cycle busy drops. Issue start op=4 at busy cycle 3 -> hi unaffected, final result correct.
- Reset mid-div at busy cycle 4 -> busy=0 next cycle, hi=lo=0. A subsequent mult then completes normally.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models fixed op latency, raises F/D stall.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, b_nz;
  logic [31:0] a_mag, b_mag, div_s, div_u;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Arithmetic datapath; divisor forced to 1 on b==0 so the dividers stay defined.
  always_comb begin
    prod_s = 64'($signed(a)) * 64'($signed(b));
    prod_u = 64'(a) * 64'(b);
    a_neg  = a[31];
    b_neg  = b[31];
    b_nz   = (b != 32'd0);
    a_mag  = a_neg ? (32'd0 - a) : a;
    b_mag  = b_neg ? (32'd0 - b) : b;
    div_s  = b_nz ? b_mag : 32'd1;
    div_u  = b_nz ? b : 32'd1;
    q_mag  = a_mag / div_s;
    r_mag  = a_mag % div_s;
    q_s    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    r_s    = a_neg ? (32'd0 - r_mag) : r_mag;
    q_u    = a / div_u;
    r_u    = a % div_u;
  end

  // Next-state, counter and HI/LO update logic.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              pend_hi_d = prod_s[63:32];
              pend_lo_d = prod_s[31:0];
              pend_wr_d = 1'b1;
              count_d   = CNT_W'(MULT_CYCLES);
              state_d   = S_RUN;
              busy_d    = 1'b1;
            end
            OP_MULTU: begin
              pend_hi_d = prod_u[63:32];
              pend_lo_d = prod_u[31:0];
              pend_wr_d = 1'b1;
              count_d   = CNT_W'(MULT_CYCLES);
              state_d   = S_RUN;
              busy_d    = 1'b1;
            end
            OP_DIV: begin
              pend_hi_d = r_s;
              pend_lo_d = q_s;
              pend_wr_d = b_nz;
              count_d   = CNT_W'(DIV_CYCLES);
              state_d   = S_RUN;
              busy_d    = 1'b1;
            end
            OP_DIVU: begin
              pend_hi_d = r_u;
              pend_lo_d = q_u;
              pend_wr_d = b_nz;
              count_d   = CNT_W'(DIV_CYCLES);
              state_d   = S_RUN;
              busy_d    = 1'b1;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (count_q == CNT_W'(1)) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          count_d = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  // Freeze F/D while a dependent instruction sits behind a running or issuing mult/div.
  assign stall_req = d_md_use & (busy_q | (start & (op <= OP_DIVU)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md_use;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .d_md_use  (d_md_use),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op for one cycle and count how many cycles busy stays high afterwards.
  task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       output int busy_cycles);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    tick();
    start = 1'b0;
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd7; d_md_use = 1'b1;
    tick();
    tick();
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_hilo: hi=%h lo=%h expected 0/0", hi, lo);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: busy=%b expected 0", busy);
    end
    checks++;
    if (stall_req !== 1'b1) begin
      errors++; $display("FAIL reset_stall_start: stall_req=%b expected 1", stall_req);
    end
    d_md_use = 1'b0;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      errors++; $display("FAIL reset_stall_nouse: stall_req=%b expected 0", stall_req);
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_release: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_mult();
    int n;
    do_op(3'd0, 32'hFFFF_FFFE, 32'd3, n);
    checks++;
    if (n !== 5) begin
      errors++; $display("FAIL mult_latency: busy cycles=%0d expected 5", n);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL mult_result: hi=%h lo=%h expected ffffffff/fffffffa", hi, lo);
    end
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3, n);
    checks++;
    if (n !== 5) begin
      errors++; $display("FAIL multu_latency: busy cycles=%0d expected 5", n);
    end
    checks++;
    if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL multu_result: hi=%h lo=%h expected 00000002/fffffffa", hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    do_op(3'd2, 32'd7, 32'hFFFF_FFFE, n);
    checks++;
    if (hi !== 32'd1 || lo !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_pos_neg: hi=%h lo=%h expected 00000001/fffffffd", hi, lo);
    end
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      errors++; $display("FAIL div_overflow: hi=%h lo=%h expected 00000000/80000000", hi, lo);
    end
    do_op(3'd3, 32'd100, 32'd7, n);
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      errors++; $display("FAIL divu_basic: hi=%h lo=%h expected 00000002/0000000e", hi, lo);
    end
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, n);
    checks++;
    if (n !== 10) begin
      errors++; $display("FAIL div_latency: busy cycles=%0d expected 10", n);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_result: hi=%h lo=%h expected ffffffff/fffffffd", hi, lo);
    end
    do_op(3'd3, 32'd7, 32'd0, n);
    checks++;
    if (n !== 10) begin
      errors++; $display("FAIL divu_zero_latency: busy cycles=%0d expected 10", n);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL divu_zero_hold: hi=%h lo=%h expected ffffffff/fffffffd", hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    d_md_use = 1'b1;
    start = 1'b1; op = 3'd4; a = 32'h1234_5678; b = 32'd0;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      errors++; $display("FAIL mthi_no_stall: stall_req=%b expected 0", stall_req);
    end
    tick();
    checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'hFFFF_FFFD || busy !== 1'b0) begin
      errors++; $display("FAIL mthi: hi=%h lo=%h busy=%b expected 12345678/fffffffd/0", hi, lo, busy);
    end
    op = 3'd5; a = 32'h9ABC_DEF0;
    tick();
    checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0 || busy !== 1'b0) begin
      errors++; $display("FAIL mtlo: hi=%h lo=%h busy=%b expected 12345678/9abcdef0/0", hi, lo, busy);
    end
    op = 3'd7; a = 32'hDEAD_0000;
    tick();
    checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0 || busy !== 1'b0) begin
      errors++; $display("FAIL reserved_op: hi=%h lo=%h busy=%b expected 12345678/9abcdef0/0", hi, lo, busy);
    end
    start = 1'b0;
    d_md_use = 1'b0;
  endtask

  task automatic test_hazard();
    int k;
    int stall_bad;
    d_md_use = 1'b1;
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
    #1;
    checks++;
    if (stall_req !== 1'b1) begin
      errors++; $display("FAIL hazard_start_stall: stall_req=%b expected 1", stall_req);
    end
    tick();
    start = 1'b0;
    k = 0;
    stall_bad = 0;
    while (busy === 1'b1 && k < 100) begin
      k++;
      if (k == 3) begin
        start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0;
      end
      #1;
      if (stall_req !== 1'b1) stall_bad++;
      tick();
    end
    start = 1'b0;
    #1;
    checks++;
    if (k !== 5) begin
      errors++; $display("FAIL hazard_latency: busy cycles=%0d expected 5", k);
    end
    checks++;
    if (stall_bad !== 0) begin
      errors++; $display("FAIL hazard_busy_stall: low stall cycles=%0d expected 0", stall_bad);
    end
    checks++;
    if (stall_req !== 1'b0) begin
      errors++; $display("FAIL hazard_release: stall_req=%b expected 0", stall_req);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd30) begin
      errors++; $display("FAIL hazard_result: hi=%h lo=%h expected 00000000/0000001e", hi, lo);
    end
    d_md_use = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int k;
    int n;
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    k = 1;
    while (k < 4) begin
      tick();
      k++;
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL midreset: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL midreset_after: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
    do_op(3'd0, 32'h0000_FFFF, 32'h0001_0001, n);
    checks++;
    if (n !== 5 || hi !== 32'd0 || lo !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL midreset_mult: cycles=%0d hi=%h lo=%h expected 5/00000000/ffffffff", n, hi, lo);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; d_md_use = 1'b0;
    #1;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_hazard();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
